// File: rtl/alu_serial_ctrl_pkg.sv
// Shared opcode and state encodings for the bit-serial ALU sequencer.
package alu_pkg;

    typedef logic [2:0] alu_op_t;

    localparam alu_op_t OP_AND = 3'b000;
    localparam alu_op_t OP_OR  = 3'b001;
    localparam alu_op_t OP_ADD = 3'b010;
    localparam alu_op_t OP_SUB = 3'b110;
    localparam alu_op_t OP_SLT = 3'b111;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // SLT is evaluated as a subtraction; the compare bit is derived afterwards.
    function automatic alu_op_t slice_op(input alu_op_t op);
        return (op[1:0] == 2'b11) ? OP_SUB : op;
    endfunction

endpackage

// File: rtl/alu_serial_ctrl_if.sv
// Request/response handshake bundle between an issuer and the serial ALU.
interface alu_serial_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
    logic             out_carry;
    logic             out_ovf;
    logic             busy;

    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_carry, out_ovf, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_carry, out_ovf, busy
    );
endinterface

// File: rtl/alu_serial_ctrl_alu_1bit.sv
// One-bit ALU slice: AND/OR/ADD/LESS with optional B inversion; carry chain always computed.
import alu_pkg::*;

module alu_1bit (
    input  logic    a_i,
    input  logic    b_i,
    input  logic    cin_i,
    input  logic    lessi_i,
    input  alu_op_t op_i,
    output logic    r_o,
    output logic    cout_o
);
    logic b_eff;

    assign b_eff  = b_i ^ op_i[2];
    assign cout_o = (a_i & b_eff) | (cin_i & (a_i ^ b_eff));

    always_comb begin
        r_o = 1'b0;
        case (op_i[1:0])
            2'b00:   r_o = a_i & b_eff;
            2'b01:   r_o = a_i | b_eff;
            2'b10:   r_o = a_i ^ b_eff ^ cin_i;
            default: r_o = lessi_i;
        endcase
    end
endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: one shared slice walks the operands LSB first, one bit per clock.
import alu_pkg::*;

module alu_serial_ctrl #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input logic              clk,
    input logic              reset,
    alu_serial_ctrl_if.slave bus
);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    alu_op_t          op_q, op_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cin_msb_q, cin_msb_d;
    logic             sum_msb_q, sum_msb_d;

    logic             slice_r;
    logic             slice_cout;

    alu_1bit u_slice (
        .a_i     (a_q[0]),
        .b_i     (b_q[0]),
        .cin_i   (carry_q),
        .lessi_i (1'b0),
        .op_i    (slice_op(op_q)),
        .r_o     (slice_r),
        .cout_o  (slice_cout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            op_q      <= '0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            cin_msb_q <= 1'b0;
            sum_msb_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_q     <= res_d;
            op_q      <= op_d;
            carry_q   <= carry_d;
            cnt_q     <= cnt_d;
            cin_msb_q <= cin_msb_d;
            sum_msb_q <= sum_msb_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        op_d      = op_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        cin_msb_d = cin_msb_q;
        sum_msb_d = sum_msb_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    op_d    = bus.in_op;
                    carry_d = bus.in_op[2];
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                res_d   = {slice_r, res_q[WIDTH-1:1]};
                carry_d = slice_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                // The MSB step keeps its carry-in and sum for overflow and SLT.
                if (cnt_q == LAST_BIT) begin
                    cin_msb_d = carry_q;
                    sum_msb_d = slice_r;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    logic             done;
    logic             is_slt;
    logic             less;
    logic [WIDTH-1:0] result_w;

    assign done     = (state_q == DONE);
    assign is_slt   = (op_q[1:0] == 2'b11);
    assign less     = sum_msb_q ^ (cin_msb_q ^ carry_q);
    assign result_w = is_slt ? {{(WIDTH-1){1'b0}}, less} : res_q;

    // Result and flags are masked outside DONE so partial words never leak out.
    assign bus.in_ready   = (state_q == IDLE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.out_valid  = done;
    assign bus.out_result = done ? result_w : '0;
    assign bus.out_zero   = done && (result_w == '0);
    assign bus.out_carry  = done && carry_q;
    assign bus.out_ovf    = done && (op_q[1:0] == 2'b10) && (cin_msb_q ^ carry_q);
endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed self-checking bench for alu_serial_ctrl with hand-computed expectations.
module tb_alu_serial_ctrl;
    localparam int WIDTH = 32;

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    int   lat;

    alu_serial_ctrl_if #(.WIDTH(WIDTH)) bus ();

    alu_serial_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issues one op, then returns the number of edges until out_valid rises.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] op, output int latency);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!bus.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) checkOutput("in_ready_wait", {63'd0, bus.in_ready}, 64'd1);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_op    = op;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_a     = 32'hDEADBEEF;
        bus.in_b     = 32'h12345678;
        bus.in_op    = 3'b001;
        latency = 0;
        do begin
            @(posedge clk);
            #1;
            latency++;
        end while (!bus.out_valid && latency < 200);
    endtask

    task automatic consume();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic checkResult(input string tag, input logic [31:0] res,
                               input logic zero, input logic carry, input logic ovf);
        checkOutput({tag, "_result"}, {32'd0, bus.out_result}, {32'd0, res});
        checkOutput({tag, "_zero"},   {63'd0, bus.out_zero},   {63'd0, zero});
        checkOutput({tag, "_carry"},  {63'd0, bus.out_carry},  {63'd0, carry});
        checkOutput({tag, "_ovf"},    {63'd0, bus.out_ovf},    {63'd0, ovf});
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_op     = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_in_ready",  {63'd0, bus.in_ready},  64'd1);
        checkOutput("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        checkOutput("rst_busy",      {63'd0, bus.busy},      64'd0);
        checkResult("rst", 32'h0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        applyStimulus(32'h7FFFFFFF, 32'h00000001, 3'b010, lat);
        checkOutput("add_latency", 64'(lat), 64'd32);
        checkResult("add_ovf", 32'h80000000, 1'b0, 1'b0, 1'b1);
        consume();

        applyStimulus(32'd5, 32'd5, 3'b110, lat);
        checkResult("sub_eq", 32'h0, 1'b1, 1'b1, 1'b0);
        consume();

        applyStimulus(32'd0, 32'd1, 3'b110, lat);
        checkResult("sub_neg", 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        consume();

        applyStimulus(32'hFFFFFFFF, 32'd1, 3'b111, lat);
        checkResult("slt_m1_1", 32'h1, 1'b0, 1'b1, 1'b0);
        consume();

        applyStimulus(32'h80000000, 32'd1, 3'b111, lat);
        checkResult("slt_min_1", 32'h1, 1'b0, 1'b1, 1'b0);
        consume();

        applyStimulus(32'd1, 32'hFFFFFFFF, 3'b111, lat);
        checkResult("slt_1_m1", 32'h0, 1'b1, 1'b0, 1'b0);
        consume();

        applyStimulus(32'd7, 32'd7, 3'b111, lat);
        checkResult("slt_eq", 32'h0, 1'b1, 1'b1, 1'b0);
        consume();

        applyStimulus(32'hF0F0F0F0, 32'h0FF00FF0, 3'b000, lat);
        checkResult("and", 32'h00F000F0, 1'b0, 1'b1, 1'b0);
        consume();

        applyStimulus(32'hF0F0F0F0, 32'h0FF00FF0, 3'b001, lat);
        checkResult("or", 32'hFFF0FFF0, 1'b0, 1'b1, 1'b0);
        consume();

        applyStimulus(32'hF0F0F0F0, 32'h0FF00FF0, 3'b100, lat);
        checkResult("andn", 32'hF000F000, 1'b0, 1'b1, 1'b0);
        consume();

        // Backpressure: DONE must hold while new requests are offered.
        applyStimulus(32'd3, 32'd4, 3'b010, lat);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.in_valid = (i % 2 == 0);
            bus.in_a     = 32'd100;
            bus.in_b     = 32'd200;
            bus.in_op    = 3'b010;
            @(posedge clk);
            #1;
            checkOutput("bp_out_valid", {63'd0, bus.out_valid}, 64'd1);
            checkOutput("bp_in_ready",  {63'd0, bus.in_ready},  64'd0);
            checkOutput("bp_busy",      {63'd0, bus.busy},      64'd1);
            checkResult("bp", 32'd7, 1'b0, 1'b0, 1'b0);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        consume();
        checkOutput("bp_idle_in_ready",  {63'd0, bus.in_ready},  64'd1);
        checkOutput("bp_idle_out_valid", {63'd0, bus.out_valid}, 64'd0);
        checkOutput("bp_idle_busy",      {63'd0, bus.busy},      64'd0);
        applyStimulus(32'd10, 32'd20, 3'b010, lat);
        checkOutput("bp_next_latency", 64'(lat), 64'd32);
        checkResult("bp_next", 32'd30, 1'b0, 1'b0, 1'b0);
        consume();

        // Reset mid-RUN aborts the operation.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a     = 32'h7FFFFFFF;
        bus.in_b     = 32'h7FFFFFFF;
        bus.in_op    = 3'b010;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        checkOutput("run_busy", {63'd0, bus.busy}, 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("abort_in_ready",  {63'd0, bus.in_ready},  64'd1);
        checkOutput("abort_out_valid", {63'd0, bus.out_valid}, 64'd0);
        checkOutput("abort_busy",      {63'd0, bus.busy},      64'd0);
        checkResult("abort", 32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(32'h00000001, 32'hFFFFFFFF, 3'b010, lat);
        checkOutput("post_abort_latency", 64'(lat), 64'd32);
        checkResult("post_abort", 32'h0, 1'b1, 1'b1, 1'b0);
        consume();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
